multicycle_control: RTL and testbench

- Multi-cycle RV32I control FSM; parametrised successor to the single-cycle decoder.
- Sequences each instruction over 3–5 states with a shared ALU and a single unified memory.
- Waits on a variable-latency memory via a req/ready handshake.
- Sits between the instruction register (op/funct fields) and the multi-cycle datapath muxes/enables.

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_control_if.sv | 48 ++++
 rtl/multicycle_control_alu_decoder.sv | 31 +++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory bundle. illegal_instr exists only with CTRL_TRAP_EN.
interface multicycle_control_if #(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int IMM_SRC_WIDTH  = 3
);
    logic [6:0]                op;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic                      zero;
    logic                      mem_ready;
    logic                      mem_req;
    logic                      mem_write;
    logic                      adr_src;
    logic                      ir_write;
    logic                      pc_write;
    logic                      reg_write;
    logic [1:0]                alu_src_a;
    logic [1:0]                alu_src_b;
    logic [ALU_CTRL_WIDTH-1:0] alu_control;
    logic [1:0]                result_src;
    logic [IMM_SRC_WIDTH-1:0]  imm_src;
    logic                      instr_done;
    logic                      mem_timeout;
`ifdef CTRL_TRAP_EN
    logic                      illegal_instr;
`endif

    modport master (
        input  op, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, imm_src,
               instr_done, mem_timeout
`ifdef CTRL_TRAP_EN
        , output illegal_instr
`endif
    );

    modport slave (
        output op, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, imm_src,
               instr_done, mem_timeout
`ifdef CTRL_TRAP_EN
        , input illegal_instr
`endif
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// funct3/funct7_5 -> ALU op for register and immediate ALU instructions.
module alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      is_rtype,
    input  logic [2:0]                funct3,
    input  logic                      funct7_5,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control
);
    logic [3:0] alu_op;

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            // srai/sra share the funct7_5 select
            3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    assign alu_control = ALU_CTRL_WIDTH'(alu_op);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM with req/ready memory wait and optional
// timeout flag. CTRL_TRAP_EN: illegal opcodes lock into TRAP instead of NOP.
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int          ALU_CTRL_WIDTH = 4,
    parameter int          IMM_SRC_WIDTH  = 3,
    parameter int unsigned MEM_TIMEOUT    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_control_if.master bus
);
    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done;
    logic [1:0] src_a, src_b, res_src;
    logic [3:0] alu_fixed;
    logic       use_dec, waiting;
    logic [ALU_CTRL_WIDTH-1:0] alu_dec;

    alu_decoder #(.ALU_CTRL_WIDTH(ALU_CTRL_WIDTH)) u_alu_dec (
        .is_rtype    (bus.op == OP_RTYPE),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .alu_control (alu_dec)
    );

    // run_q holds all outputs at zero until the first edge after reset release
    assign run_d = 1'b1;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        res_src    = RES_ALUOUT;
        alu_fixed  = ALU_ADD;
        use_dec    = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    src_b   = SRCB_FOUR;
                    res_src = RES_ALU;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    src_a = SRCA_OLDPC;
                    src_b = SRCB_IMM;
                    case (bus.op)
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                        OP_RTYPE:          state_d = S_EXEC_R;
                        OP_ITYPE:          state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
`ifdef CTRL_TRAP_EN
                        default:           state_d = S_TRAP;
`else
                        default: begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
`endif
                    endcase
                end
                S_MEM_ADR: begin
                    src_a   = SRCA_RS1;
                    src_b   = SRCB_IMM;
                    state_d = (bus.op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (bus.mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    res_src    = RES_RDATA;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (bus.mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_EXEC_R, S_EXEC_I: begin
                    src_a   = SRCA_RS1;
                    src_b   = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                    use_dec = 1'b1;
                    state_d = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    src_a      = SRCA_RS1;
                    alu_fixed  = ALU_SUB;
                    pc_write   = (bus.funct3[2:1] == 2'b00) && (bus.zero ^ bus.funct3[0]);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JALR: begin
                    src_a   = SRCA_RS1;
                    src_b   = SRCB_IMM;
                    state_d = S_JAL;
                end
                S_JAL: begin
                    src_a    = SRCA_OLDPC;
                    src_b    = SRCB_FOUR;
                    pc_write = 1'b1;
                    state_d  = S_ALU_WB;
                end
                S_LUI: begin
                    src_a   = SRCA_ZERO;
                    src_b   = SRCB_IMM;
                    state_d = S_ALU_WB;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign waiting = run_q && !bus.mem_ready &&
                     (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE);

    // count restarts whenever a wait ends or a non-wait state is visited
    always_comb begin
        cnt_d = '0;
        tmo_d = tmo_q;
        if (MEM_TIMEOUT != 0 && waiting && !tmo_q) begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_d >= MEM_TIMEOUT) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_write   = mem_write;
    assign bus.adr_src     = adr_src;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.instr_done  = instr_done;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.result_src  = res_src;
    assign bus.alu_control = use_dec ? alu_dec : ALU_CTRL_WIDTH'(alu_fixed);
    assign bus.imm_src     = run_q ? IMM_SRC_WIDTH'(imm_src_of(bus.op)) : '0;
    assign bus.mem_timeout = tmo_q;
`ifdef CTRL_TRAP_EN
    assign bus.illegal_instr = run_q && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: expected output vector per cycle is queued as inputs are driven.
module tb_multicycle_control;

    logic gclk = 1'b0;
    logic grst_n = 1'b0;
    always #5 gclk = ~gclk;

    multicycle_control_if #(.ALU_CTRL_WIDTH(4), .IMM_SRC_WIDTH(3)) bus ();

    multicycle_control #(.ALU_CTRL_WIDTH(4), .IMM_SRC_WIDTH(3), .MEM_TIMEOUT(4)) dut (
        .clk   (gclk),
        .rst_n (grst_n),
        .bus   (bus.master)
    );

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JR = 7'b1100111, BAD = 7'b0000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,instr_done,mem_timeout,A,B,res,imm,alu}
    function automatic logic [20:0] pack();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.instr_done, bus.mem_timeout, bus.alu_src_a,
                bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_control};
    endfunction

    function automatic logic [20:0] ex(input logic [7:0] s, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic [2:0] imm, input logic [3:0] alu);
        return {s, a, b, rs, imm, alu};
    endfunction

    function automatic logic [20:0] e_fetch(input logic rdy, input logic [2:0] imm);
        return ex(rdy ? 8'b1001_1000 : 8'b1000_0000, 2'b00, 2'b10, 2'b10, imm, 4'b0000);
    endfunction

    function automatic logic [20:0] e_dec(input logic [2:0] imm);
        return ex(8'b0000_0000, 2'b01, 2'b01, 2'b00, imm, 4'b0000);
    endfunction

    function automatic logic [20:0] e_wb(input logic [1:0] rs);
        return ex(8'b0000_0110, 2'b00, 2'b00, rs, 3'b000, 4'b0000);
    endfunction

    task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic z, input logic rdy, input logic [20:0] e);
        bus.op = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = z; bus.mem_ready = rdy;
        sb.push_back('{tag, e});
        @(posedge gclk); #1;
    endtask

    always @(negedge gclk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, {11'd0, pack()}, {11'd0, e.v});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op = BAD; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge gclk);
        #1 chk("reset", {11'd0, pack()}, 32'd0);
        @(negedge gclk) grst_n = 1'b1;
        @(posedge gclk); #1;

        cyc("add.F",  R, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("add.D",  R, 3'b000, 1'b0, 1'b0, 1'b1, e_dec(3'b000));
        cyc("add.X",  R, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000));
        cyc("add.WB", R, 3'b000, 1'b0, 1'b0, 1'b1, e_wb(2'b00));

        cyc("sub.F",  R, 3'b000, 1'b1, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("sub.D",  R, 3'b000, 1'b1, 1'b0, 1'b1, e_dec(3'b000));
        cyc("sub.X",  R, 3'b000, 1'b1, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001));
        cyc("sub.WB", R, 3'b000, 1'b1, 1'b0, 1'b1, e_wb(2'b00));

        cyc("srai.F",  I, 3'b101, 1'b1, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("srai.D",  I, 3'b101, 1'b1, 1'b0, 1'b1, e_dec(3'b000));
        cyc("srai.X",  I, 3'b101, 1'b1, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0111));
        cyc("srai.WB", I, 3'b101, 1'b1, 1'b0, 1'b1, e_wb(2'b00));

        cyc("addi.F",  I, 3'b000, 1'b1, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("addi.D",  I, 3'b000, 1'b1, 1'b0, 1'b1, e_dec(3'b000));
        cyc("addi.X",  I, 3'b000, 1'b1, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000));
        cyc("addi.WB", I, 3'b000, 1'b1, 1'b0, 1'b1, e_wb(2'b00));

        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw.Fw%0d", i), LD, 3'b010, 1'b0, 1'b0, 1'b0, e_fetch(1'b0, 3'b000));
        cyc("lw.F",  LD, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("lw.D",  LD, 3'b010, 1'b0, 1'b0, 1'b1, e_dec(3'b000));
        cyc("lw.MA", LD, 3'b010, 1'b0, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw.Rw%0d", i), LD, 3'b010, 1'b0, 1'b0, 1'b0,
                ex(8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        cyc("lw.R",  LD, 3'b010, 1'b0, 1'b0, 1'b1, ex(8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        cyc("lw.WB", LD, 3'b010, 1'b0, 1'b0, 1'b1, e_wb(2'b01));

        cyc("sw.F",  ST, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1, 3'b001));
        cyc("sw.D",  ST, 3'b010, 1'b0, 1'b0, 1'b1, e_dec(3'b001));
        cyc("sw.MA", ST, 3'b010, 1'b0, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000));
        cyc("sw.Ww", ST, 3'b010, 1'b0, 1'b0, 1'b0, ex(8'b1110_0000, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000));
        cyc("sw.W",  ST, 3'b010, 1'b0, 1'b0, 1'b1, ex(8'b1110_0010, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000));

        cyc("beq.F", BR, 3'b000, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 3'b010));
        cyc("beq.D", BR, 3'b000, 1'b0, 1'b1, 1'b1, e_dec(3'b010));
        cyc("beq.B", BR, 3'b000, 1'b0, 1'b1, 1'b1, ex(8'b0000_1010, 2'b10, 2'b00, 2'b00, 3'b010, 4'b0001));
        cyc("bne.F", BR, 3'b001, 1'b0, 1'b1, 1'b1, e_fetch(1'b1, 3'b010));
        cyc("bne.D", BR, 3'b001, 1'b0, 1'b1, 1'b1, e_dec(3'b010));
        cyc("bne.B", BR, 3'b001, 1'b0, 1'b1, 1'b1, ex(8'b0000_0010, 2'b10, 2'b00, 2'b00, 3'b010, 4'b0001));

        cyc("jalr.F",  JR, 3'b000, 1'b0, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("jalr.D",  JR, 3'b000, 1'b0, 1'b0, 1'b1, e_dec(3'b000));
        cyc("jalr.JR", JR, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000));
        cyc("jalr.J",  JR, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'b0000_1000, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000));
        cyc("jalr.WB", JR, 3'b000, 1'b0, 1'b0, 1'b1, e_wb(2'b00));

        // abandon a load mid-wait with an asynchronous reset
        cyc("rlw.F",  LD, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1, 3'b000));
        cyc("rlw.D",  LD, 3'b010, 1'b0, 1'b0, 1'b1, e_dec(3'b000));
        cyc("rlw.MA", LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(8'h00, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000));
        cyc("rlw.Rw", LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(8'b1010_0000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        #1 grst_n = 1'b0;
        #1 chk("rst_async", {11'd0, pack()}, 32'd0);
        bus.op = BAD;
        @(negedge gclk) grst_n = 1'b1;
        @(posedge gclk); #1;

        // no ready for 4 fetch cycles trips the timeout, which then stays set
        for (int i = 0; i < 4; i++)
            cyc($sformatf("tmo.Fw%0d", i), BAD, 3'b000, 1'b0, 1'b0, 1'b0, e_fetch(1'b0, 3'b000));
        cyc("tmo.set", BAD, 3'b000, 1'b0, 1'b0, 1'b0, ex(8'b1000_0001, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000));
        cyc("ill.F",   BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'b1001_1001, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000));
`ifdef CTRL_TRAP_EN
        cyc("ill.D",   BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'b0000_0001, 2'b01, 2'b01, 2'b00, 3'b000, 4'b0000));
        chk("illegal", {31'd0, bus.illegal_instr}, 32'd1);
        cyc("trap0",   R,   3'b000, 1'b0, 1'b0, 1'b1, ex(8'b0000_0001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        cyc("trap1",   R,   3'b000, 1'b0, 1'b0, 1'b1, ex(8'b0000_0001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000));
        chk("illegal_held", {31'd0, bus.illegal_instr}, 32'd1);
`else
        cyc("ill.D",   BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex(8'b0000_0011, 2'b01, 2'b01, 2'b00, 3'b000, 4'b0000));
        cyc("ill.F2",  BAD, 3'b000, 1'b0, 1'b0, 1'b0, ex(8'b1000_0001, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000));
`endif

        @(negedge gclk); #1;
        chk("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
